dynode_integrate_pool: RTL and testbench
========================================

// Module: dynode_integrate_pool
// PURPOSE
//  Parametrised successor of the dynode energy integrator in the dynode trigger path. Holds NENG
//  independent integration engines, each with its own ADC and baseline accumulators. Each
//  dyn_event is allocated to a free engine, which integrates a per-event start delay and length.
//  Completed energies go out on a valid/ready stream carrying timestamp, sample count and pile-up flag.
// PARAMETERS
//  ADC_W   8   dynode ADC sample width
//  BL_W    16  baseline width; dyn_curval[3:0] are fractional bits
//  CNT_W   4   integcount/startdly width; maximum integration length is 2**CNT_W-1
//  TIME_W  24  event timestamp width
//  NENG    2   number of integration engines, 1..8
//  SUM_W   12  output energy width, saturating
//  DROP_W  8   drop counter width, saturating
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  integcount  in   CNT_W   samples per integration; 0 treated as 1
//  startdly    in   CNT_W   cycles from event to first integrated sample
//  cfg_trunc   in   1       1: new event truncates in-flight integrations; 0: integrations overlap
//  dyn_adcdly  in   ADC_W   delayed dynode ADC sample
//  dyn_curval  in   BL_W    baseline, 4 fractional bits
//  dyn_event   in   1       event strobe, one cycle per event
//  evntim      in   TIME_W  event time, valid with dyn_event
//  ene_valid   out  1       result available
//  ene_ready   in   1       consumer accepts when ene_valid&&ene_ready
//  dyn_energy  out  SUM_W   baseline-corrected energy
//  dyn_ingcnt  out  CNT_W   samples actually integrated
//  dyn_evntim  out  TIME_W  timestamp of the event
//  ene_trunc   out  1       integration was cut short by a later event
//  drop_cnt    out  DROP_W  events lost because no engine was idle
// BEHAVIOUR
//  Reset: all engines IDLE, accumulators 0. ene_valid=0; dyn_energy, dyn_ingcnt, dyn_evntim,
//   ene_trunc and drop_cnt are 0. Assertion mid-operation discards in-flight work and the held output.
//  Allocation: on dyn_event, take the lowest-index engine that is IDLE at that edge (registered state).
//   The engine latches evntim, N=max(integcount,1) and D=startdly. With no IDLE engine, drop the event
//   and increment drop_cnt; drop_cnt saturates at all-ones.
//  Engine FSM: IDLE -> DELAY when D>0, or straight to INTEG when D=0.
//   DELAY counts D-1 further cycles, then goes to INTEG. INTEG accumulates N samples, then goes to DONE.
//   DONE holds the result until the output arbiter grants it, then returns to IDLE.
//   A released engine is not allocatable in the same cycle as its grant.
//  Sampling: for an event at edge t, accumulate dyn_adcdly/dyn_curval at edges t+D .. t+D+N-1.
//   With D=0, the sample present with dyn_event is included.
//  Arithmetic:
//   adc_sum = sum(dyn_adcdly), ADC_W+CNT_W bits. bl_sum = sum(dyn_curval), BL_W+CNT_W bits.
//   energy = adc_sum - (bl_sum>>4). A negative result clamps to 0; a result above 2**SUM_W-1 saturates.
//  Truncation (cfg_trunc=1): an allocating dyn_event at edge e stops every other engine in DELAY or INTEG.
//   The sample at edge e is excluded. Each stopped engine goes to DONE with ingcnt = samples taken so far
//   (0 if it was still in DELAY, energy then 0) and ene_trunc=1.
//   A dropped event does not truncate anything.
//   With cfg_trunc=0, integrations overlap and ene_trunc is always 0.
//  Output stage: a single output register.
//   Round-robin arbitration among DONE engines, with the pointer advanced past each winner.
//   The register loads when empty, or when a transfer occurs in the same cycle; full throughput is 1/cycle.
//   Outputs are stable while ene_valid&&!ene_ready.
//  Latency: event at t with no contention gives ene_valid high after edge t+D+N+1.
//  Config changes affect only subsequently allocated events.
// STRUCTURE
//  dynode_pkg: engine state enum (ENG_IDLE, ENG_DELAY, ENG_INTEG, ENG_DONE), width localparams,
//   and a saturate/clamp function.
//  Sub-module dynode_integ_engine: FSM, counters and accumulators, instantiated NENG times.
//   Allocation, drop counter, truncation broadcast and the round-robin output register stay in the top.
// TESTING
//  1. N=4, D=0, adc=50, curval=16'h0140, event at t -> energy 120, ingcnt 4, evntim echoed,
//     valid after t+5, trunc 0.
//  2. N=3, D=3, adc ramp 10,11,12..., curval 0, event at t -> sums the ramp values at edges t+3..t+5.
//  3. cfg_trunc=1, NENG=2, N=8, second event 2 edges after the first -> first result ingcnt 2, trunc 1;
//     second result ingcnt 8.
//  4. NENG=2, three events on consecutive edges, cfg_trunc=0 -> two results, drop_cnt=1.
//     Repeat 300 drops -> drop_cnt holds at 255.
//  5. ene_ready=0 with 2 engines DONE -> outputs hold, engines stay DONE, events are dropped;
//     ready=1 -> back-to-back transfers in round-robin order.
//  6. adc=0, curval=16'h0FF0 -> energy 0 (clamp). adc=255, N=15, curval 0 -> 3825.
//     reset_n low mid-INTEG -> all outputs 0, next event integrates cleanly.

Source files
------------

// File: rtl/dynode_pkg.sv
// Shared definitions for the dynode integration pool.
// Contents:
//   eng_state_t  - integration engine state
//   DEF_*        - default widths and engine count
//   sat_clamp    - clamps a signed value into 0..max_value
package dynode_pkg;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_DELAY,
        ENG_INTEG,
        ENG_DONE
    } eng_state_t;

    localparam int unsigned DEF_ADC_W  = 8;
    localparam int unsigned DEF_BL_W   = 16;
    localparam int unsigned DEF_CNT_W  = 4;
    localparam int unsigned DEF_TIME_W = 24;
    localparam int unsigned DEF_NENG   = 2;
    localparam int unsigned DEF_SUM_W  = 12;
    localparam int unsigned DEF_DROP_W = 8;

    function automatic int unsigned sat_clamp(input int value, input int unsigned max_value);
        if (value < 0) begin
            return 0;
        end
        if (unsigned'(value) > max_value) begin
            return max_value;
        end
        return unsigned'(value);
    endfunction

endpackage

// File: rtl/dynode_integ_engine.sv
// One integration engine: waits the start delay, accumulates ADC and
// baseline samples, then holds the clamped energy until granted.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start             allocate this engine (only honoured while IDLE)
//   start_len/dly     integration length (0 -> 1) and start delay
//   start_time        event timestamp to carry with the result
//   stop              truncate an in-flight integration
//   adc, curval       current ADC sample and baseline (4 fraction bits)
//   grant             output register has taken the result
//   state             engine state
//   energy/ingcnt/evtime/trunc  held result
module dynode_integ_engine
    import dynode_pkg::*;
#(
    parameter int unsigned ADC_W  = DEF_ADC_W,
    parameter int unsigned BL_W   = DEF_BL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned SUM_W  = DEF_SUM_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  start_len,
    input  logic [CNT_W-1:0]  start_dly,
    input  logic [TIME_W-1:0] start_time,
    input  logic              stop,
    input  logic [ADC_W-1:0]  adc,
    input  logic [BL_W-1:0]   curval,
    input  logic              grant,
    output eng_state_t        state,
    output logic [SUM_W-1:0]  energy,
    output logic [CNT_W-1:0]  ingcnt,
    output logic [TIME_W-1:0] evtime,
    output logic              trunc
);

    localparam int unsigned AW      = ADC_W + CNT_W;
    localparam int unsigned BW      = BL_W + CNT_W;
    localparam int unsigned SUM_MAX = (1 << SUM_W) - 1;

    logic [AW-1:0]    adc_acc;
    logic [BW-1:0]    bl_acc;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] taken;
    logic [SUM_W-1:0] cur_energy;

    always_comb begin
        cur_energy = SUM_W'(sat_clamp(int'(adc_acc) - int'(bl_acc >> 4), SUM_MAX));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ENG_IDLE;
            adc_acc <= '0;
            bl_acc  <= '0;
            len     <= '0;
            dly     <= '0;
            taken   <= '0;
            energy  <= '0;
            ingcnt  <= '0;
            evtime  <= '0;
            trunc   <= 1'b0;
        end else begin
            case (state)
                ENG_IDLE: begin
                    if (start) begin
                        evtime <= start_time;
                        len    <= (start_len == '0) ? CNT_W'(1) : start_len;
                        trunc  <= 1'b0;
                        // Zero delay: the sample present with the event is the first one.
                        if (start_dly == '0) begin
                            state   <= ENG_INTEG;
                            adc_acc <= AW'(adc);
                            bl_acc  <= BW'(curval);
                            taken   <= CNT_W'(1);
                        end else begin
                            state   <= ENG_DELAY;
                            dly     <= start_dly - 1'b1;
                            adc_acc <= '0;
                            bl_acc  <= '0;
                            taken   <= '0;
                        end
                    end
                end
                ENG_DELAY: begin
                    if (stop) begin
                        state  <= ENG_DONE;
                        energy <= '0;
                        ingcnt <= '0;
                        trunc  <= 1'b1;
                    end else if (dly == '0) begin
                        state   <= ENG_INTEG;
                        adc_acc <= AW'(adc);
                        bl_acc  <= BW'(curval);
                        taken   <= CNT_W'(1);
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
                ENG_INTEG: begin
                    // A full window completes normally even if a truncating event arrives now.
                    if (taken == len) begin
                        state  <= ENG_DONE;
                        energy <= cur_energy;
                        ingcnt <= taken;
                    end else if (stop) begin
                        state  <= ENG_DONE;
                        energy <= cur_energy;
                        ingcnt <= taken;
                        trunc  <= 1'b1;
                    end else begin
                        adc_acc <= adc_acc + AW'(adc);
                        bl_acc  <= bl_acc + BW'(curval);
                        taken   <= taken + 1'b1;
                    end
                end
                ENG_DONE: begin
                    if (grant) begin
                        state <= ENG_IDLE;
                    end
                end
                default: state <= ENG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dynode_integrate_pool.sv
// Pool of NENG dynode energy integration engines with event allocation,
// drop counting, optional truncation and a round-robin output register.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   integcount, startdly      per-event length (0 -> 1) and start delay
//   cfg_trunc                 new events cut short in-flight integrations
//   dyn_adcdly, dyn_curval    ADC sample and baseline (4 fraction bits)
//   dyn_event, evntim         event strobe and its timestamp
//   ene_valid, ene_ready      output handshake
//   dyn_energy, dyn_ingcnt, dyn_evntim, ene_trunc   result fields
//   drop_cnt                  saturating count of events with no idle engine
module dynode_integrate_pool
    import dynode_pkg::*;
#(
    parameter int unsigned ADC_W  = DEF_ADC_W,
    parameter int unsigned BL_W   = DEF_BL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned TIME_W = DEF_TIME_W,
    parameter int unsigned NENG   = DEF_NENG,
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CNT_W-1:0]  integcount,
    input  logic [CNT_W-1:0]  startdly,
    input  logic              cfg_trunc,
    input  logic [ADC_W-1:0]  dyn_adcdly,
    input  logic [BL_W-1:0]   dyn_curval,
    input  logic              dyn_event,
    input  logic [TIME_W-1:0] evntim,
    output logic              ene_valid,
    input  logic              ene_ready,
    output logic [SUM_W-1:0]  dyn_energy,
    output logic [CNT_W-1:0]  dyn_ingcnt,
    output logic [TIME_W-1:0] dyn_evntim,
    output logic              ene_trunc,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned PTR_W = (NENG > 1) ? $clog2(NENG) : 1;

    eng_state_t        eng_state  [NENG];
    logic [SUM_W-1:0]  eng_energy [NENG];
    logic [CNT_W-1:0]  eng_ingcnt [NENG];
    logic [TIME_W-1:0] eng_evtime [NENG];
    logic              eng_trunc  [NENG];

    logic [NENG-1:0]  start_sel;
    logic [NENG-1:0]  grant_sel;
    logic             any_idle;
    logic             stop;
    logic             load;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] rr_ptr;

    // Lowest-index IDLE engine takes the event.
    always_comb begin
        start_sel = '0;
        any_idle  = 1'b0;
        for (int unsigned i = 0; i < NENG; i++) begin
            if (!any_idle && eng_state[i] == ENG_IDLE) begin
                start_sel[i] = dyn_event;
                any_idle     = 1'b1;
            end
        end
    end

    assign stop = dyn_event && any_idle && cfg_trunc;
    assign load = !ene_valid || ene_ready;

    // Round robin: search rr_ptr..NENG-1 first, then wrap to 0..rr_ptr-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        grant_sel = '0;
        for (int unsigned i = 0; i < NENG; i++) begin
            if (!win_found && i >= 32'(rr_ptr) && eng_state[i] == ENG_DONE) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NENG; i++) begin
            if (!win_found && i < 32'(rr_ptr) && eng_state[i] == ENG_DONE) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NENG; i++) begin
            grant_sel[i] = load && win_found && (32'(win_idx) == i);
        end
    end

    for (genvar g = 0; g < NENG; g++) begin : g_eng
        dynode_integ_engine #(
            .ADC_W (ADC_W),
            .BL_W  (BL_W),
            .CNT_W (CNT_W),
            .TIME_W(TIME_W),
            .SUM_W (SUM_W)
        ) u_eng (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start_sel[g]),
            .start_len (integcount),
            .start_dly (startdly),
            .start_time(evntim),
            .stop      (stop),
            .adc       (dyn_adcdly),
            .curval    (dyn_curval),
            .grant     (grant_sel[g]),
            .state     (eng_state[g]),
            .energy    (eng_energy[g]),
            .ingcnt    (eng_ingcnt[g]),
            .evtime    (eng_evtime[g]),
            .trunc     (eng_trunc[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ene_valid  <= 1'b0;
            dyn_energy <= '0;
            dyn_ingcnt <= '0;
            dyn_evntim <= '0;
            ene_trunc  <= 1'b0;
            drop_cnt   <= '0;
            rr_ptr     <= '0;
        end else begin
            if (dyn_event && !any_idle && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (load) begin
                if (win_found) begin
                    ene_valid  <= 1'b1;
                    dyn_energy <= eng_energy[win_idx];
                    dyn_ingcnt <= eng_ingcnt[win_idx];
                    dyn_evntim <= eng_evtime[win_idx];
                    ene_trunc  <= eng_trunc[win_idx];
                    rr_ptr     <= (32'(win_idx) + 1 >= NENG) ? '0 : win_idx + 1'b1;
                end else begin
                    ene_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dynode_integrate_pool.sv
// Bench for dynode_integrate_pool: table of single-event cases, hand-built
// truncation / drop / backpressure / reset sequences, then random traffic,
// with every cycle compared against a window-based reference model.
module tb_dynode_integrate_pool;

    localparam int NENG    = 2;
    localparam int SUM_MAX = 4095;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  integcount = '0;
    logic [3:0]  startdly = '0;
    logic        cfg_trunc = 1'b0;
    logic [7:0]  dyn_adcdly = '0;
    logic [15:0] dyn_curval = '0;
    logic        dyn_event = 1'b0;
    logic [23:0] evntim = '0;
    logic        ene_valid;
    logic        ene_ready = 1'b1;
    logic [11:0] dyn_energy;
    logic [3:0]  dyn_ingcnt;
    logic [23:0] dyn_evntim;
    logic        ene_trunc;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    dynode_integrate_pool #(
        .ADC_W (8),
        .BL_W  (16),
        .CNT_W (4),
        .TIME_W(24),
        .NENG  (NENG),
        .SUM_W (12),
        .DROP_W(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .integcount(integcount),
        .startdly  (startdly),
        .cfg_trunc (cfg_trunc),
        .dyn_adcdly(dyn_adcdly),
        .dyn_curval(dyn_curval),
        .dyn_event (dyn_event),
        .evntim    (evntim),
        .ene_valid (ene_valid),
        .ene_ready (ene_ready),
        .dyn_energy(dyn_energy),
        .dyn_ingcnt(dyn_ingcnt),
        .dyn_evntim(dyn_evntim),
        .ene_trunc (ene_trunc),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        int n; int d; int base; int step; int cv;
        int e_energy; int e_cnt; int e_lat;
    } vec_t;

    typedef struct {
        int cyc; int energy; int cnt; int tim; int trunc;
    } xfer_t;

    vec_t  vecs [7];
    xfer_t xq [$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;

    // Reference model: each engine is a sample window [start, start+cnt-1]
    // that becomes DONE at edge done_at; results come from the sample history.
    int adc_hist [int];
    int cv_hist  [int];
    bit m_busy  [NENG];
    int m_start [NENG];
    int m_n     [NENG];
    int m_cnt   [NENG];
    int m_done  [NENG];
    bit m_tr    [NENG];
    int m_time  [NENG];
    bit m_valid;
    int m_energy, m_cnto, m_timo, m_drop, m_ptr;
    bit m_tro;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int energy_of(input int s, input int cnt);
        int sa = 0;
        int sb = 0;
        int e;
        for (int k = s; k < s + cnt; k++) begin
            sa += adc_hist[k];
            sb += cv_hist[k];
        end
        e = sa - (sb >> 4);
        if (e < 0) e = 0;
        if (e > SUM_MAX) e = SUM_MAX;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENG; i++) m_busy[i] = 1'b0;
        m_valid = 1'b0; m_energy = 0; m_cnto = 0; m_timo = 0; m_tro = 1'b0;
        m_drop = 0; m_ptr = 0;
    endtask

    task automatic model_edge();
        int c = cyc;
        bit done_pre [NENG];
        bit ld;
        int win = -1;
        int a = -1;
        adc_hist[c] = int'(dyn_adcdly);
        cv_hist[c]  = int'(dyn_curval);
        for (int i = 0; i < NENG; i++) done_pre[i] = m_busy[i] && (m_done[i] < c);
        ld = !m_valid || ene_ready;
        if (ld) begin
            for (int k = 0; k < NENG; k++) begin
                int idx = (m_ptr + k) % NENG;
                if (win < 0 && done_pre[idx]) win = idx;
            end
        end
        if (dyn_event) begin
            for (int i = 0; i < NENG; i++) if (a < 0 && !m_busy[i]) a = i;
            if (a < 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                if (cfg_trunc) begin
                    for (int j = 0; j < NENG; j++) begin
                        if (j != a && m_busy[j] && !done_pre[j] && (m_start[j] + m_n[j] - 1 >= c)) begin
                            m_cnt[j]  = (c > m_start[j]) ? c - m_start[j] : 0;
                            m_done[j] = c;
                            m_tr[j]   = 1'b1;
                        end
                    end
                end
                m_busy[a]  = 1'b1;
                m_n[a]     = (int'(integcount) == 0) ? 1 : int'(integcount);
                m_start[a] = c + int'(startdly);
                m_cnt[a]   = m_n[a];
                m_done[a]  = m_start[a] + m_n[a];
                m_tr[a]    = 1'b0;
                m_time[a]  = int'(evntim);
            end
        end
        if (ld) begin
            if (win >= 0) begin
                m_valid  = 1'b1;
                m_energy = energy_of(m_start[win], m_cnt[win]);
                m_cnto   = m_cnt[win];
                m_timo   = m_time[win];
                m_tro    = m_tr[win];
                m_busy[win] = 1'b0;
                m_ptr    = (win + 1) % NENG;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: log a transfer happening at this edge, advance the model,
    // clock the DUT and compare every output.
    task automatic tick();
        if (ene_valid && ene_ready) begin
            xfer_t x;
            x.cyc = cyc; x.energy = int'(dyn_energy); x.cnt = int'(dyn_ingcnt);
            x.tim = int'(dyn_evntim); x.trunc = int'(ene_trunc);
            xq.push_back(x);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("ene_valid", ene_valid, m_valid);
        chk("dyn_energy", dyn_energy, m_energy);
        chk("dyn_ingcnt", dyn_ingcnt, m_cnto);
        chk("dyn_evntim", dyn_evntim, m_timo);
        chk("ene_trunc", ene_trunc, m_tro);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #3;
        chk("rst_valid", ene_valid, 0);
        chk("rst_energy", dyn_energy, 0);
        chk("rst_ingcnt", dyn_ingcnt, 0);
        chk("rst_evntim", dyn_evntim, 0);
        chk("rst_trunc", ene_trunc, 0);
        chk("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        dyn_event = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic event_tick(input int tim);
        dyn_event = 1'b1;
        evntim = 24'(tim);
        tick();
        dyn_event = 1'b0;
    endtask

    task automatic wait_xfers(input int want, input int budget);
        for (int i = 0; i < budget && xq.size() < want; i++) tick();
        chk("xfer_count", xq.size(), want);
    endtask

    task automatic run_row(input int r, input vec_t v);
        int t;
        int tim;
        tim = int'($urandom_range(1, 24'hFFFFFF));
        integcount = 4'(v.n); startdly = 4'(v.d); dyn_curval = 16'(v.cv);
        cfg_trunc = 1'b0; ene_ready = 1'b1; evntim = 24'(tim);
        xq.delete();
        t = cyc;
        for (int k = 0; k < 40 && xq.size() == 0; k++) begin
            dyn_adcdly = 8'(v.base + v.step * k);
            dyn_event = (k == 0);
            tick();
        end
        dyn_event = 1'b0;
        chk($sformatf("row%0d_xfer", r), xq.size(), 1);
        if (xq.size() > 0) begin
            chk($sformatf("row%0d_energy", r), xq[0].energy, v.e_energy);
            chk($sformatf("row%0d_ingcnt", r), xq[0].cnt, v.e_cnt);
            chk($sformatf("row%0d_evntim", r), xq[0].tim, tim);
            chk($sformatf("row%0d_trunc", r), xq[0].trunc, 0);
            chk($sformatf("row%0d_latency", r), xq[0].cyc - t - 1, v.e_lat);
        end
        idle(2);
    endtask

    initial begin
        vecs[0] = '{4,  0,  50, 0, 16'h0140,  120,  4,  5};
        vecs[1] = '{3,  3,  10, 1, 16'h0000,   42,  3,  7};
        vecs[2] = '{4,  0,   0, 0, 16'h0FF0,    0,  4,  5};
        vecs[3] = '{15, 0, 255, 0, 16'h0000, 3825, 15, 16};
        vecs[4] = '{0,  0,  77, 0, 16'h0020,   75,  1,  2};
        vecs[5] = '{2,  1, 100, 1, 16'h0018,  200,  2,  4};
        vecs[6] = '{15, 15, 200, 0, 16'h0105, 2756, 15, 31};

        model_reset();
        do_reset();
        idle(2);

        for (int r = 0; r < 7; r++) run_row(r, vecs[r]);

        // Truncation: second event two edges after the first.
        cfg_trunc = 1'b1; integcount = 4'd8; startdly = 4'd0;
        dyn_adcdly = 8'd9; dyn_curval = '0; ene_ready = 1'b1;
        xq.delete();
        event_tick(111);
        idle(1);
        event_tick(222);
        wait_xfers(2, 30);
        if (xq.size() == 2) begin
            chk("trunc_first_cnt", xq[0].cnt, 2);
            chk("trunc_first_flag", xq[0].trunc, 1);
            chk("trunc_first_energy", xq[0].energy, 18);
            chk("trunc_first_tim", xq[0].tim, 111);
            chk("trunc_second_cnt", xq[1].cnt, 8);
            chk("trunc_second_flag", xq[1].trunc, 0);
            chk("trunc_second_energy", xq[1].energy, 72);
        end
        cfg_trunc = 1'b0;
        idle(2);

        // Three events on consecutive edges: one dropped.
        do_reset();
        integcount = 4'd4; xq.delete();
        event_tick(1);
        event_tick(2);
        event_tick(3);
        wait_xfers(2, 30);
        chk("drop_one", drop_cnt, 1);
        if (xq.size() == 2) begin
            chk("drop_res0_tim", xq[0].tim, 1);
            chk("drop_res1_tim", xq[1].tim, 2);
        end
        idle(3);

        // Backpressure: register full plus both engines DONE, then release.
        ene_ready = 1'b0; integcount = 4'd2; xq.delete();
        event_tick(10);
        event_tick(11);
        idle(4);
        event_tick(12);
        idle(4);
        dyn_event = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        dyn_event = 1'b0;
        chk("drop_saturate", drop_cnt, 255);
        chk("hold_valid", ene_valid, 1);
        chk("hold_evntim", dyn_evntim, 10);
        ene_ready = 1'b1;
        idle(5);
        chk("rr_xfers", xq.size(), 3);
        if (xq.size() == 3) begin
            chk("rr_order0", xq[0].tim, 10);
            chk("rr_order1", xq[1].tim, 11);
            chk("rr_order2", xq[2].tim, 12);
            chk("rr_b2b_a", xq[1].cyc - xq[0].cyc, 1);
            chk("rr_b2b_b", xq[2].cyc - xq[1].cyc, 1);
        end

        // Reset mid-integration, then a clean event.
        integcount = 4'd15; dyn_adcdly = 8'd30;
        event_tick(77);
        idle(5);
        do_reset();
        integcount = 4'd4; xq.delete();
        begin
            int t0;
            t0 = cyc;
            event_tick(78);
            wait_xfers(1, 20);
            if (xq.size() == 1) begin
                chk("post_rst_energy", xq[0].energy, 120);
                chk("post_rst_cnt", xq[0].cnt, 4);
                chk("post_rst_lat", xq[0].cyc - t0 - 1, 5);
            end
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            dyn_event  = ($urandom_range(0, 3) == 0);
            integcount = 4'($urandom_range(0, 15));
            startdly   = 4'($urandom_range(0, 5));
            cfg_trunc  = 1'($urandom_range(0, 1));
            dyn_adcdly = 8'($urandom_range(0, 255));
            dyn_curval = 16'($urandom_range(0, 16'h0FFF));
            ene_ready  = ($urandom_range(0, 9) < 7);
            evntim     = 24'($urandom);
            tick();
        end
        dyn_event = 1'b0;
        ene_ready = 1'b1;
        idle(40);
        chk("final_drained", ene_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
